ws2812b_frame_scheduler: RTL and testbench



---
 rtl/ws2812b_frame_scheduler_pkg.sv | 24 ++
 rtl/ws2812b_frame_scheduler_if.sv | 37 +++
 rtl/ws2812b_frame_scheduler_led_fetch.sv | 96 +++++++++
 rtl/ws2812b_frame_scheduler.sv | 143 ++++++++++++++
 tb/tb_ws2812b_frame_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812b_frame_scheduler_pkg.sv
// rtl/ws2812b_frame_scheduler_pkg.sv - shared constants, state encoding and sizing helper
// Purpose: definitions shared by the frame scheduler, its LED fetch unit and the bus interface.
// Ports: none (package).
package ws2812b_pkg;

  localparam int BYTES_PER_LED = 3;

  // Colour byte order inside one stripe's 3-byte group in BRAM.
  localparam int COL_G = 0;
  localparam int COL_R = 1;
  localparam int COL_B = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2
  } sched_state_t;

  // Bytes occupied by one full frame (one bank) in BRAM.
  function automatic int frame_bytes(input int led_count, input int stripe_count);
    return led_count * BYTES_PER_LED * stripe_count;
  endfunction

endpackage

// File: rtl/ws2812b_frame_scheduler_if.sv
// rtl/ws2812b_frame_scheduler_if.sv - BRAM read bus plus bitstream handshake
// Purpose: bundles the BRAM read port and the bitstream available/read handshake.
// Ports (signals):
//   mem_addr            scheduler -> BRAM      read address
//   mem_data            BRAM -> scheduler      read data, one cycle after mem_addr
//   bitstream           scheduler -> consumer  packed GRB word, all stripes
//   bitstream_available scheduler -> consumer  word valid and waiting
//   bitstream_read      consumer -> scheduler  single-cycle accept pulse
// Modports: master = scheduler side, slave = BRAM/consumer side.
interface ws2812b_frame_scheduler_if #(
  parameter int STRIPE_COUNT = 2,
  parameter int ADDR_WIDTH   = 14
);

  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [7:0]                mem_data;
  logic [24*STRIPE_COUNT-1:0] bitstream;
  logic                      bitstream_available;
  logic                      bitstream_read;

  modport master (
    output mem_addr,
    output bitstream,
    output bitstream_available,
    input  mem_data,
    input  bitstream_read
  );

  modport slave (
    input  mem_addr,
    input  bitstream,
    input  bitstream_available,
    output mem_data,
    output bitstream_read
  );

endinterface

// File: rtl/ws2812b_frame_scheduler_led_fetch.sv
// rtl/ws2812b_frame_scheduler_led_fetch.sv - fetches and packs all colour bytes of one LED position
// Purpose: on start, issues N = 3*STRIPE_COUNT consecutive BRAM addresses from base_addr,
//          captures each returned byte one cycle later into its packed GRB slot and
//          raises done in the cycle the last byte is being captured.
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   start         single-cycle request; base_addr is sampled with it
//   base_addr     address of byte 0 (stripe 0, G) of the LED position
//   mem_addr      BRAM read address; holds its last value when idle
//   mem_data      BRAM read data
//   bitstream     packed word; stripe s at [24s+23:24s], G/R/B high to low
//   done          last byte is on mem_data and is written this cycle
module ws2812b_led_fetch
  import ws2812b_pkg::*;
#(
  parameter int STRIPE_COUNT = 2,
  parameter int ADDR_WIDTH   = 14
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  input  logic [7:0]                 mem_data,
  output logic [24*STRIPE_COUNT-1:0] bitstream,
  output logic                       done
);

  localparam int N     = BYTES_PER_LED * STRIPE_COUNT;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic                       issuing_q, issuing_d;
  logic [IDX_W-1:0]           issue_idx_q, issue_idx_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic                       cap_valid_q, cap_valid_d;
  logic [IDX_W-1:0]           cap_idx_q, cap_idx_d;
  logic [24*STRIPE_COUNT-1:0] bits_q, bits_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      issuing_q   <= 1'b0;
      issue_idx_q <= '0;
      addr_q      <= '0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      bits_q      <= '0;
    end else begin
      issuing_q   <= issuing_d;
      issue_idx_q <= issue_idx_d;
      addr_q      <= addr_d;
      cap_valid_q <= cap_valid_d;
      cap_idx_q   <= cap_idx_d;
      bits_q      <= bits_d;
    end
  end

  // Address issue: one byte per cycle, address register holds once the run ends.
  always_comb begin
    issuing_d   = issuing_q;
    issue_idx_d = issue_idx_q;
    addr_d      = addr_q;
    if (start) begin
      issuing_d   = 1'b1;
      issue_idx_d = '0;
      addr_d      = base_addr;
    end else if (issuing_q) begin
      if (issue_idx_q == LAST_IDX) begin
        issuing_d = 1'b0;
      end else begin
        issue_idx_d = issue_idx_q + 1'b1;
        addr_d      = addr_q + 1'b1;
      end
    end
  end

  // Capture pipeline trails the issue stage by the one-cycle BRAM latency.
  always_comb begin
    cap_valid_d = issuing_q;
    cap_idx_d   = issue_idx_q;
    bits_d      = bits_q;
    if (cap_valid_q) begin
      for (int n = 0; n < N; n++) begin
        // Byte n is stripe n/3, colour n%3; G lands in the top byte of the stripe group.
        if (cap_idx_q == IDX_W'(n)) begin
          bits_d[24*(n/BYTES_PER_LED) + 8*(COL_B - (n % BYTES_PER_LED)) +: 8] = mem_data;
        end
      end
    end
  end

  assign mem_addr  = addr_q;
  assign bitstream = bits_q;
  assign done      = cap_valid_q && (cap_idx_q == LAST_IDX);

endmodule

// File: rtl/ws2812b_frame_scheduler.sv
// rtl/ws2812b_frame_scheduler.sv - streams one LED frame from BRAM to the WS2812B output stage
// Purpose: on frame_tick walks all LED positions of the display bank, fetching and packing each
//          position's bytes for every stripe and presenting them with an available/read
//          handshake. Owns ping-pong bank selection; banks swap only at frame start.
// Ports:
//   clk, resetn    clock, synchronous active-low reset
//   frame_tick     frame start request (single-cycle strobe)
//   wr_frame_done  writer finished the write bank (single-cycle strobe)
//   bus            master side of BRAM read port + bitstream handshake
//   busy           frame in progress
//   frame_done     single-cycle pulse after the last LED is accepted
//   disp_bank      bank being displayed; write bank is ~disp_bank
//   overrun_count  frame_tick strobes dropped while busy, saturating at 255
module ws2812b_frame_scheduler
  import ws2812b_pkg::*;
#(
  parameter int STRIPE_COUNT = 2,
  parameter int LED_COUNT    = 121,
  parameter int ADDR_WIDTH   = 14
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             frame_tick,
  input  logic                             wr_frame_done,
  ws2812b_frame_scheduler_if.master        bus,
  output logic                             busy,
  output logic                             frame_done,
  output logic                             disp_bank,
  output logic [7:0]                       overrun_count
);

  localparam int N     = BYTES_PER_LED * STRIPE_COUNT;
  localparam int FB    = frame_bytes(LED_COUNT, STRIPE_COUNT);
  localparam int LED_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
  localparam logic [LED_W-1:0]      LAST_LED  = LED_W'(LED_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(FB);
  localparam logic [ADDR_WIDTH-1:0] LED_STEP   = ADDR_WIDTH'(N);

  sched_state_t          state_q, state_d;
  logic [LED_W-1:0]      led_idx_q, led_idx_d;
  logic [ADDR_WIDTH-1:0] led_base_q, led_base_d;
  logic                  disp_bank_q, disp_bank_d;
  logic                  swap_pending_q, swap_pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [7:0]            overrun_q, overrun_d;

  logic                  fetch_start;
  logic                  fetch_done;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [24*STRIPE_COUNT-1:0] fetch_bits;

  wire last_led = (led_idx_q == LAST_LED);
  wire accepted = (state_q == ST_PRESENT) && bus.bitstream_read;

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      led_idx_q      <= '0;
      led_base_q     <= '0;
      disp_bank_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= '0;
    end else begin
      state_q        <= state_d;
      led_idx_q      <= led_idx_d;
      led_base_q     <= led_base_d;
      disp_bank_q    <= disp_bank_d;
      swap_pending_q <= swap_pending_d;
      frame_done_q   <= frame_done_d;
      overrun_q      <= overrun_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (frame_tick) state_d = ST_FETCH;
      ST_FETCH:   if (fetch_done) state_d = ST_PRESENT;
      ST_PRESENT: if (bus.bitstream_read) state_d = last_led ? ST_IDLE : ST_FETCH;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    fetch_start    = 1'b0;
    led_idx_d      = led_idx_q;
    led_base_d     = led_base_q;
    disp_bank_d    = disp_bank_q;
    frame_done_d   = 1'b0;
    overrun_d      = overrun_q;
    // Strobes coalesce; the pending swap is consumed only when a frame starts.
    swap_pending_d = swap_pending_q | wr_frame_done;

    if (state_q == ST_IDLE && frame_tick) begin
      disp_bank_d    = disp_bank_q ^ (swap_pending_q | wr_frame_done);
      swap_pending_d = 1'b0;
      led_idx_d      = '0;
      led_base_d     = disp_bank_d ? BANK1_BASE : '0;
      fetch_start    = 1'b1;
    end

    if (state_q != ST_IDLE && frame_tick && overrun_q != 8'hFF) begin
      overrun_d = overrun_q + 8'd1;
    end

    if (accepted) begin
      if (last_led) begin
        frame_done_d = 1'b1;
      end else begin
        led_idx_d   = led_idx_q + 1'b1;
        led_base_d  = led_base_q + LED_STEP;
        fetch_start = 1'b1;
      end
    end
  end

  ws2812b_led_fetch #(
    .STRIPE_COUNT (STRIPE_COUNT),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_led_fetch (
    .clk       (clk),
    .resetn    (resetn),
    .start     (fetch_start),
    .base_addr (led_base_d),
    .mem_addr  (fetch_addr),
    .mem_data  (bus.mem_data),
    .bitstream (fetch_bits),
    .done      (fetch_done)
  );

  assign bus.mem_addr            = fetch_addr;
  assign bus.bitstream           = fetch_bits;
  assign bus.bitstream_available = (state_q == ST_PRESENT);
  assign busy                    = (state_q != ST_IDLE);
  assign frame_done              = frame_done_q;
  assign disp_bank               = disp_bank_q;
  assign overrun_count           = overrun_q;

endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// tb/tb_ws2812b_frame_scheduler.sv - directed self-checking bench for ws2812b_frame_scheduler
module tb_ws2812b_frame_scheduler;

  localparam int STRIPE_COUNT = 2;
  localparam int LED_COUNT    = 2;
  localparam int ADDR_WIDTH   = 14;

  localparam logic [47:0] W_B0_L0 = 48'h030405_000102;
  localparam logic [47:0] W_B0_L1 = 48'h090A0B_060708;
  localparam logic [47:0] W_B1_L0 = 48'h0F1011_0C0D0E;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic       wr_frame_done;
  logic       busy;
  logic       frame_done;
  logic       disp_bank;
  logic [7:0] overrun_count;

  int checks = 0;
  int errors = 0;

  ws2812b_frame_scheduler_if #(.STRIPE_COUNT(STRIPE_COUNT), .ADDR_WIDTH(ADDR_WIDTH)) bus_if ();

  ws2812b_frame_scheduler #(
    .STRIPE_COUNT (STRIPE_COUNT),
    .LED_COUNT    (LED_COUNT),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .frame_tick    (frame_tick),
    .wr_frame_done (wr_frame_done),
    .bus           (bus_if),
    .busy          (busy),
    .frame_done    (frame_done),
    .disp_bank     (disp_bank),
    .overrun_count (overrun_count)
  );

  always #5 clk = ~clk;

  // BRAM model: each byte equals the low 8 bits of its address, one-cycle read latency.
  always @(posedge clk) bus_if.mem_data <= bus_if.mem_addr[7:0];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic pulse_read();
    bus_if.bitstream_read = 1'b1;
    step();
    bus_if.bitstream_read = 1'b0;
  endtask

  task automatic wait_avail(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus_if.bitstream_available === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic consume(input int n, output bit ok);
    bit ok1;
    ok = 1'b1;
    for (int j = 0; j < n; j++) begin
      wait_avail(ok1);
      if (!ok1) begin
        ok = 1'b0;
        return;
      end
      step();
      step();
      pulse_read();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    frame_tick = 1'b0;
    wr_frame_done = 1'b0;
    bus_if.bitstream_read = 1'b0;
    step(); step(); step();
    checks++;
    if ({busy, frame_done, disp_bank, bus_if.bitstream_available} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {busy, frame_done, disp_bank, bus_if.bitstream_available});
    end
    checks++;
    if (bus_if.mem_addr !== 14'd0 || bus_if.bitstream !== 48'd0 || overrun_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_data got addr=%0d bits=%h ovr=%0d want 0/0/0", bus_if.mem_addr, bus_if.bitstream, overrun_count);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_frame();
    pulse_tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL start_busy got %b want 1", busy);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (bus_if.mem_addr !== 14'(k) || bus_if.bitstream_available !== 1'b0) begin
        errors++;
        $display("FAIL led0_addr k=%0d got addr=%0d avail=%b want addr=%0d avail=0", k, bus_if.mem_addr, bus_if.bitstream_available, k);
      end
      step();
    end
    checks++;
    if (bus_if.bitstream_available !== 1'b0) begin
      errors++;
      $display("FAIL avail_early got %b want 0", bus_if.bitstream_available);
    end
    step();
    checks++;
    if (bus_if.bitstream_available !== 1'b1 || bus_if.bitstream !== W_B0_L0) begin
      errors++;
      $display("FAIL led0_word got avail=%b bits=%h want 1 %h", bus_if.bitstream_available, bus_if.bitstream, W_B0_L0);
    end
    step(); step();
    checks++;
    if (bus_if.bitstream_available !== 1'b1 || bus_if.bitstream !== W_B0_L0) begin
      errors++;
      $display("FAIL led0_hold got avail=%b bits=%h want 1 %h", bus_if.bitstream_available, bus_if.bitstream, W_B0_L0);
    end
    pulse_read();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (bus_if.mem_addr !== 14'(6 + k) || bus_if.bitstream_available !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL led1_addr k=%0d got addr=%0d avail=%b busy=%b want addr=%0d avail=0 busy=1", k, bus_if.mem_addr, bus_if.bitstream_available, busy, 6 + k);
      end
      step();
    end
    step();
    checks++;
    if (bus_if.bitstream_available !== 1'b1 || bus_if.bitstream !== W_B0_L1) begin
      errors++;
      $display("FAIL led1_word got avail=%b bits=%h want 1 %h", bus_if.bitstream_available, bus_if.bitstream, W_B0_L1);
    end
    step(); step();
    pulse_read();
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || bus_if.bitstream_available !== 1'b0) begin
      errors++;
      $display("FAIL frame_end got done=%b busy=%b avail=%b want 1 0 0", frame_done, busy, bus_if.bitstream_available);
    end
    step();
    checks++;
    if (frame_done !== 1'b0 || bus_if.mem_addr !== 14'd11) begin
      errors++;
      $display("FAIL frame_after got done=%b addr=%0d want 0 11", frame_done, bus_if.mem_addr);
    end
  endtask

  task automatic test_bank_swap();
    bit ok;
    pulse_tick();
    step();
    wr_frame_done = 1'b1;
    step();
    wr_frame_done = 1'b0;
    step();
    wr_frame_done = 1'b1;
    step();
    wr_frame_done = 1'b0;
    checks++;
    if (disp_bank !== 1'b0) begin
      errors++;
      $display("FAIL bank_midframe got %b want 0", disp_bank);
    end
    consume(LED_COUNT, ok);
    checks++;
    if (!ok || disp_bank !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bank_frame_end got ok=%b bank=%b busy=%b want 1 0 0", ok, disp_bank, busy);
    end
    step();
    pulse_tick();
    checks++;
    if (disp_bank !== 1'b1 || bus_if.mem_addr !== 14'd12) begin
      errors++;
      $display("FAIL bank_swap got bank=%b addr=%0d want 1 12", disp_bank, bus_if.mem_addr);
    end
    wait_avail(ok);
    checks++;
    if (!ok || bus_if.bitstream !== W_B1_L0) begin
      errors++;
      $display("FAIL bank1_word got ok=%b bits=%h want 1 %h", ok, bus_if.bitstream, W_B1_L0);
    end
    consume(LED_COUNT, ok);
    step();
  endtask

  task automatic test_overrun();
    bit ok;
    int cnt;
    pulse_tick();
    cnt = 0;
    for (int c = 1; c < 64; c++) begin
      if (bus_if.bitstream_available === 1'b1) break;
      frame_tick = (c == 2 || c == 4);
      step();
      frame_tick = 1'b0;
      cnt++;
    end
    checks++;
    if (overrun_count !== 8'd2) begin
      errors++;
      $display("FAIL overrun_two got %0d want 2", overrun_count);
    end
    checks++;
    if (cnt !== 7 || bus_if.bitstream !== W_B1_L0 || disp_bank !== 1'b1) begin
      errors++;
      $display("FAIL overrun_norestart got cycles=%0d bits=%h bank=%b want 7 %h 1", cnt, bus_if.bitstream, disp_bank, W_B1_L0);
    end
    frame_tick = 1'b1;
    for (int c = 0; c < 300; c++) step();
    frame_tick = 1'b0;
    checks++;
    if (overrun_count !== 8'd255 || bus_if.bitstream_available !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sat got cnt=%0d avail=%b want 255 1", overrun_count, bus_if.bitstream_available);
    end
    consume(LED_COUNT, ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL overrun_finish got ok=%b busy=%b want 1 0", ok, busy);
    end
    step();
  endtask

  task automatic test_spurious_read();
    bit ok;
    int cnt;
    pulse_tick();
    step();
    bus_if.bitstream_read = 1'b1;
    step();
    step();
    bus_if.bitstream_read = 1'b0;
    cnt = 0;
    for (int c = 0; c < 64; c++) begin
      if (bus_if.bitstream_available === 1'b1) break;
      step();
      cnt++;
    end
    checks++;
    if (cnt !== 4 || bus_if.bitstream !== W_B1_L0 || bus_if.mem_addr !== 14'd17) begin
      errors++;
      $display("FAIL spurious_read got cycles=%0d bits=%h addr=%0d want 4 %h 17", cnt, bus_if.bitstream, bus_if.mem_addr, W_B1_L0);
    end
    consume(LED_COUNT, ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL spurious_finish got ok=%b busy=%b want 1 0", ok, busy);
    end
    step();
  endtask

  task automatic test_reset_midframe();
    bit ok;
    pulse_tick();
    wait_avail(ok);
    checks++;
    if (!ok || disp_bank !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got ok=%b bank=%b want 1 1", ok, disp_bank);
    end
    resetn = 1'b0;
    step();
    checks++;
    if ({busy, frame_done, disp_bank, bus_if.bitstream_available} !== 4'b0000 ||
        bus_if.mem_addr !== 14'd0 || bus_if.bitstream !== 48'd0 || overrun_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid got flags=%b addr=%0d bits=%h ovr=%0d want 0000 0 0 0",
               {busy, frame_done, disp_bank, bus_if.bitstream_available}, bus_if.mem_addr, bus_if.bitstream, overrun_count);
    end
    resetn = 1'b1;
    step();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_nodone got done=%b busy=%b want 0 0", frame_done, busy);
    end
    pulse_tick();
    checks++;
    if (bus_if.mem_addr !== 14'd0 || disp_bank !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart got addr=%0d bank=%b busy=%b want 0 0 1", bus_if.mem_addr, disp_bank, busy);
    end
    wait_avail(ok);
    checks++;
    if (!ok || bus_if.bitstream !== W_B0_L0) begin
      errors++;
      $display("FAIL rst_word got ok=%b bits=%h want 1 %h", ok, bus_if.bitstream, W_B0_L0);
    end
    consume(LED_COUNT, ok);
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_finish got ok=%b busy=%b want 1 0", ok, busy);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_bank_swap();
    test_overrun();
    test_spurious_read();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
